// File: rtl/mem_arbiter_if.sv
// Bundle between the L1 caches, the memory arbiter and main memory.
// slave is the arbiter side, master the cache/memory side.
interface mem_arbiter_if;
    logic         icache_req_ren;
    logic [31:0]  icache_req_raddr;
    logic         icache_rec_en;
    logic [31:0]  icache_rec_addr;
    logic [127:0] icache_rec_cacheline;

    logic         dcache_req_ren;
    logic [31:0]  dcache_req_raddr;
    logic         dcache_req_wen;
    logic [31:0]  dcache_req_waddr;
    logic [127:0] dcache_req_wcacheline;
    logic         dcache_rec_en;
    logic [31:0]  dcache_rec_addr;
    logic [127:0] dcache_rec_cacheline;

    logic         mem_req_valid;
    logic         mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_data;

    logic         busy;
    logic         overflow;

    modport slave (
        input  icache_req_ren, icache_req_raddr,
        output icache_rec_en, icache_rec_addr, icache_rec_cacheline,
        input  dcache_req_ren, dcache_req_raddr,
        input  dcache_req_wen, dcache_req_waddr, dcache_req_wcacheline,
        output dcache_rec_en, dcache_rec_addr, dcache_rec_cacheline,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_rsp_valid, mem_rsp_data,
        output busy, overflow
    );

    modport master (
        output icache_req_ren, icache_req_raddr,
        input  icache_rec_en, icache_rec_addr, icache_rec_cacheline,
        output dcache_req_ren, dcache_req_raddr,
        output dcache_req_wen, dcache_req_waddr, dcache_req_wcacheline,
        input  dcache_rec_en, dcache_rec_addr, dcache_rec_cacheline,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_rsp_valid, mem_rsp_data,
        input  busy, overflow
    );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: queues icache/dcache line requests and serialises
// them onto the single memory port, routing fill data back to its owner.
module mem_arbiter #(
    parameter int QDEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state;

    logic [PW:0]   iq_wp, iq_rp;
    logic [PW:0]   dq_wp, dq_rp;
    logic [PW:0]   wq_wp, wq_rp;
    logic [31:0]   iq_a [QDEPTH];
    logic [31:0]   dq_a [QDEPTH];
    logic [31:0]   wq_a [QDEPTH];
    logic [127:0]  wq_d [QDEPTH];

    logic iq_empty, dq_empty, wq_empty;
    logic iq_full, dq_full, wq_full;
    logic pop_i, pop_d, pop_w;
    logic push_i, push_d, push_w;
    logic drop;
    logic idle;
    logic last_d;
    logic cur_d;

    assign iq_empty = (iq_wp == iq_rp);
    assign dq_empty = (dq_wp == dq_rp);
    assign wq_empty = (wq_wp == wq_rp);

    // Same slot index with opposite wrap bits means the ring is full
    assign iq_full = (iq_wp[PW-1:0] == iq_rp[PW-1:0]) && (iq_wp[PW] != iq_rp[PW]);
    assign dq_full = (dq_wp[PW-1:0] == dq_rp[PW-1:0]) && (dq_wp[PW] != dq_rp[PW]);
    assign wq_full = (wq_wp[PW-1:0] == wq_rp[PW-1:0]) && (wq_wp[PW] != wq_rp[PW]);

    assign idle  = (state == S_IDLE);
    assign pop_w = idle & ~wq_empty;
    assign pop_i = idle & wq_empty & ~iq_empty & (dq_empty | last_d);
    assign pop_d = idle & wq_empty & ~dq_empty & (iq_empty | ~last_d);

    assign push_i = bus.icache_req_ren & (~iq_full | pop_i);
    assign push_d = bus.dcache_req_ren & (~dq_full | pop_d);
    assign push_w = bus.dcache_req_wen & (~wq_full | pop_w);

    assign drop = (bus.icache_req_ren & iq_full & ~pop_i)
                | (bus.dcache_req_ren & dq_full & ~pop_d)
                | (bus.dcache_req_wen & wq_full & ~pop_w);

    assign bus.busy = ~(iq_empty & dq_empty & wq_empty) | ~idle
                    | bus.icache_rec_en | bus.dcache_rec_en;

    always_ff @(posedge clk) begin
        if (push_i) iq_a[iq_wp[PW-1:0]] <= bus.icache_req_raddr;
        if (push_d) dq_a[dq_wp[PW-1:0]] <= bus.dcache_req_raddr;
        if (push_w) begin
            wq_a[wq_wp[PW-1:0]] <= bus.dcache_req_waddr;
            wq_d[wq_wp[PW-1:0]] <= bus.dcache_req_wcacheline;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= S_IDLE;
            iq_wp                    <= '0;
            iq_rp                    <= '0;
            dq_wp                    <= '0;
            dq_rp                    <= '0;
            wq_wp                    <= '0;
            wq_rp                    <= '0;
            last_d                   <= 1'b1;
            cur_d                    <= 1'b0;
            bus.overflow             <= 1'b0;
            bus.mem_req_valid        <= 1'b0;
            bus.mem_req_we           <= 1'b0;
            bus.mem_req_addr         <= '0;
            bus.mem_req_wdata        <= '0;
            bus.icache_rec_en        <= 1'b0;
            bus.icache_rec_addr      <= '0;
            bus.icache_rec_cacheline <= '0;
            bus.dcache_rec_en        <= 1'b0;
            bus.dcache_rec_addr      <= '0;
            bus.dcache_rec_cacheline <= '0;
        end else begin
            if (push_i) iq_wp <= iq_wp + (PW+1)'(1);
            if (push_d) dq_wp <= dq_wp + (PW+1)'(1);
            if (push_w) wq_wp <= wq_wp + (PW+1)'(1);
            if (pop_i)  iq_rp <= iq_rp + (PW+1)'(1);
            if (pop_d)  dq_rp <= dq_rp + (PW+1)'(1);
            if (pop_w)  wq_rp <= wq_rp + (PW+1)'(1);
            if (drop)   bus.overflow <= 1'b1;

            bus.mem_req_valid <= 1'b0;
            bus.icache_rec_en <= 1'b0;
            bus.dcache_rec_en <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    unique case (1'b1)
                        pop_w: begin
                            state             <= S_ISSUE;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_we    <= 1'b1;
                            bus.mem_req_addr  <= wq_a[wq_rp[PW-1:0]];
                            bus.mem_req_wdata <= wq_d[wq_rp[PW-1:0]];
                        end
                        pop_i: begin
                            state             <= S_ISSUE;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_we    <= 1'b0;
                            bus.mem_req_addr  <= iq_a[iq_rp[PW-1:0]];
                            cur_d             <= 1'b0;
                            last_d            <= 1'b0;
                        end
                        pop_d: begin
                            state             <= S_ISSUE;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_we    <= 1'b0;
                            bus.mem_req_addr  <= dq_a[dq_rp[PW-1:0]];
                            cur_d             <= 1'b1;
                            last_d            <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        state <= S_IDLE;
                        // mem_req_addr/we still hold the in-flight request
                        if (!bus.mem_req_we && cur_d) begin
                            bus.dcache_rec_en        <= 1'b1;
                            bus.dcache_rec_addr      <= bus.mem_req_addr;
                            bus.dcache_rec_cacheline <= bus.mem_rsp_data;
                        end else if (!bus.mem_req_we) begin
                            bus.icache_rec_en        <= 1'b1;
                            bus.icache_rec_addr      <= bus.mem_req_addr;
                            bus.icache_rec_cacheline <= bus.mem_rsp_data;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level queue model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // ---------------- memory responder ----------------
    int lat_fixed = 0;
    int late_cnt  = 0;
    int late_seen = 0;
    int rcnt      = 0;
    logic [127:0] mem_arr [logic [31:0]];
    logic [127:0] rdata_pend;

    initial begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        rdata_pend        = '0;
        mem_arr[32'h1040] = {8{16'hA5A5}};
        forever begin
            @(posedge clk);
            #2;
            bus.mem_rsp_valid = 1'b0;
            if (rst) begin
                rcnt = 0;
            end else if (late_seen != late_cnt) begin
                late_seen         = late_cnt;
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = {4{32'hDEAD_BEEF}};
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = rdata_pend;
                end
            end else if (bus.mem_req_valid) begin
                rcnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
                if (bus.mem_req_we)
                    mem_arr[bus.mem_req_addr] = bus.mem_req_wdata;
                else if (mem_arr.exists(bus.mem_req_addr))
                    rdata_pend = mem_arr[bus.mem_req_addr];
                else
                    rdata_pend = {4{bus.mem_req_addr ^ 32'h5A5A_0000}};
            end
        end
    end

    // ---------------- behavioural model + compare ----------------
    logic [31:0]  qi[$];
    logic [31:0]  qd[$];
    logic [31:0]  qwa[$];
    logic [127:0] qwd[$];
    int           stage;
    bit           m_last_d, m_rst;
    bit           c_we, c_d;
    logic [31:0]  c_a;
    logic [127:0] c_wd;
    bit           e_ovf, e_ien, e_den, e_busy;
    logic [31:0]  e_ia, e_da;
    logic [127:0] e_id, e_dd;

    logic [31:0]  req_a[$];
    bit           req_we[$];
    logic [31:0]  irec_a[$];
    logic [127:0] irec_d[$];
    int           irec_cyc[$];
    logic [31:0]  drec_a[$];
    logic [127:0] drec_d[$];

    initial begin
        stage = 0; m_last_d = 1; m_rst = 0;
        c_we = 0; c_d = 0; c_a = '0; c_wd = '0;
        e_ovf = 0; e_ien = 0; e_den = 0; e_busy = 0;
        e_ia = '0; e_da = '0; e_id = '0; e_dd = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                qi.delete(); qd.delete(); qwa.delete(); qwd.delete();
                stage = 0; m_last_d = 1; m_rst = 1;
                c_we = 0; c_a = '0; c_wd = '0;
                e_ovf = 0; e_ien = 0; e_den = 0;
                e_ia = '0; e_da = '0; e_id = '0; e_dd = '0;
            end else begin
                m_rst = 0; e_ien = 0; e_den = 0;
                if (stage == 0) begin
                    if (qwa.size() > 0) begin
                        c_we = 1; c_a = qwa.pop_front(); c_wd = qwd.pop_front();
                        stage = 1;
                    end else if (qi.size() > 0 && (qd.size() == 0 || m_last_d)) begin
                        c_we = 0; c_d = 0; c_a = qi.pop_front();
                        m_last_d = 0; stage = 1;
                    end else if (qd.size() > 0) begin
                        c_we = 0; c_d = 1; c_a = qd.pop_front();
                        m_last_d = 1; stage = 1;
                    end
                end else if (stage == 1) begin
                    stage = 2;
                end else if (bus.mem_rsp_valid) begin
                    stage = 0;
                    if (!c_we && c_d) begin
                        e_den = 1; e_da = c_a; e_dd = bus.mem_rsp_data;
                    end else if (!c_we) begin
                        e_ien = 1; e_ia = c_a; e_id = bus.mem_rsp_data;
                    end
                end
                // pops already applied, so a same-cycle pop frees a slot
                if (bus.icache_req_ren) begin
                    if (qi.size() < QD) qi.push_back(bus.icache_req_raddr);
                    else e_ovf = 1;
                end
                if (bus.dcache_req_ren) begin
                    if (qd.size() < QD) qd.push_back(bus.dcache_req_raddr);
                    else e_ovf = 1;
                end
                if (bus.dcache_req_wen) begin
                    if (qwa.size() < QD) begin
                        qwa.push_back(bus.dcache_req_waddr);
                        qwd.push_back(bus.dcache_req_wcacheline);
                    end else e_ovf = 1;
                end
            end
            e_busy = (qi.size() + qd.size() + qwa.size() > 0) || stage != 0
                     || e_ien || e_den;
            #1;
            if (m_rst) begin
                chk("rst_mem_req_valid", 128'(bus.mem_req_valid), '0);
                chk("rst_mem_req_we", 128'(bus.mem_req_we), '0);
                chk("rst_mem_req_addr", 128'(bus.mem_req_addr), '0);
                chk("rst_mem_req_wdata", bus.mem_req_wdata, '0);
            end else begin
                chk("mem_req_valid", 128'(bus.mem_req_valid), 128'(stage == 1));
                if (stage == 1) begin
                    chk("mem_req_we", 128'(bus.mem_req_we), 128'(c_we));
                    chk("mem_req_addr", 128'(bus.mem_req_addr), 128'(c_a));
                    if (c_we) chk("mem_req_wdata", bus.mem_req_wdata, c_wd);
                end
            end
            chk("icache_rec_en", 128'(bus.icache_rec_en), 128'(e_ien));
            chk("icache_rec_addr", 128'(bus.icache_rec_addr), 128'(e_ia));
            chk("icache_rec_line", bus.icache_rec_cacheline, e_id);
            chk("dcache_rec_en", 128'(bus.dcache_rec_en), 128'(e_den));
            chk("dcache_rec_addr", 128'(bus.dcache_rec_addr), 128'(e_da));
            chk("dcache_rec_line", bus.dcache_rec_cacheline, e_dd);
            chk("rec_overlap", 128'(bus.icache_rec_en & bus.dcache_rec_en), '0);
            chk("overflow", 128'(bus.overflow), 128'(e_ovf));
            chk("busy", 128'(bus.busy), 128'(e_busy));
            if (bus.mem_req_valid) begin
                req_a.push_back(bus.mem_req_addr);
                req_we.push_back(bus.mem_req_we);
            end
            if (bus.icache_rec_en) begin
                irec_a.push_back(bus.icache_rec_addr);
                irec_d.push_back(bus.icache_rec_cacheline);
                irec_cyc.push_back(cyc);
            end
            if (bus.dcache_rec_en) begin
                drec_a.push_back(bus.dcache_rec_addr);
                drec_d.push_back(bus.dcache_rec_cacheline);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nx();
        @(negedge clk);
        bus.icache_req_ren = 1'b0;
        bus.dcache_req_ren = 1'b0;
        bus.dcache_req_wen = 1'b0;
    endtask

    task automatic do_reset();
        nx();
        rst = 1'b1;
        nx();
        nx();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        nx();
        while ((bus.busy || rcnt != 0) && k < budget) begin
            nx();
            k++;
        end
        chk("wait_idle_bound", 128'(k < budget), 128'(1));
    endtask

    int c0, bi, bd, br;

    initial begin
        bus.icache_req_ren        = 1'b0;
        bus.icache_req_raddr      = '0;
        bus.dcache_req_ren        = 1'b0;
        bus.dcache_req_raddr      = '0;
        bus.dcache_req_wen        = 1'b0;
        bus.dcache_req_waddr      = '0;
        bus.dcache_req_wcacheline = '0;

        // single icache fill, L=3
        do_reset();
        lat_fixed = 3;
        bi = irec_a.size(); bd = drec_a.size();
        bus.icache_req_ren   = 1'b1;
        bus.icache_req_raddr = 32'h0000_1040;
        c0 = cyc;
        nx();
        while (cyc < c0 + 6) nx();
        chk("t1_busy_c6", 128'(bus.busy), 128'(1));
        nx();
        chk("t1_busy_c7", 128'(bus.busy), '0);
        chk("t1_irec_n", 128'(irec_a.size() - bi), 128'(1));
        if (irec_a.size() > bi) begin
            chk("t1_irec_cycle", 128'(irec_cyc[bi] - c0), 128'(6));
            chk("t1_irec_addr", 128'(irec_a[bi]), 128'(32'h0000_1040));
            chk("t1_irec_data", irec_d[bi], {8{16'hA5A5}});
        end
        chk("t1_drec_n", 128'(drec_a.size() - bd), '0);

        // same-cycle icache read, dcache read, dcache write
        do_reset();
        lat_fixed = 0;
        bi = irec_a.size(); bd = drec_a.size(); br = req_a.size();
        bus.icache_req_ren        = 1'b1;
        bus.icache_req_raddr      = 32'h100;
        bus.dcache_req_ren        = 1'b1;
        bus.dcache_req_raddr      = 32'h200;
        bus.dcache_req_wen        = 1'b1;
        bus.dcache_req_waddr      = 32'h300;
        bus.dcache_req_wcacheline = {4{32'h3333_0300}};
        wait_idle(100);
        chk("t2_req_n", 128'(req_a.size() - br), 128'(3));
        if (req_a.size() >= br + 3) begin
            chk("t2_req0", 128'({req_we[br], req_a[br]}), 128'({1'b1, 32'h300}));
            chk("t2_req1", 128'({req_we[br+1], req_a[br+1]}), 128'({1'b0, 32'h100}));
            chk("t2_req2", 128'({req_we[br+2], req_a[br+2]}), 128'({1'b0, 32'h200}));
        end
        chk("t2_irec_n", 128'(irec_a.size() - bi), 128'(1));
        chk("t2_drec_n", 128'(drec_a.size() - bd), 128'(1));
        if (irec_a.size() > bi) chk("t2_irec_addr", 128'(irec_a[bi]), 128'(32'h100));
        if (drec_a.size() > bd) chk("t2_drec_addr", 128'(drec_a[bd]), 128'(32'h200));

        // round-robin between icache and dcache
        do_reset();
        br = req_a.size();
        for (int k = 0; k < 3; k++) begin
            bus.icache_req_ren   = 1'b1;
            bus.icache_req_raddr = 32'h1000 + 32'(k * 64);
            bus.dcache_req_ren   = 1'b1;
            bus.dcache_req_raddr = 32'h2000 + 32'(k * 64);
            nx();
        end
        wait_idle(200);
        chk("t3_req_n", 128'(req_a.size() - br), 128'(6));
        if (req_a.size() >= br + 6) begin
            for (int k = 0; k < 6; k++) begin
                logic [31:0] want;
                want = ((k % 2 == 0) ? 32'h1000 : 32'h2000) + 32'((k / 2) * 64);
                chk($sformatf("t3_grant%0d", k), 128'(req_a[br+k]), 128'(want));
            end
        end

        // overflow while memory stalls
        do_reset();
        bi = irec_a.size(); bd = drec_a.size();
        lat_fixed = 30;
        bus.icache_req_ren   = 1'b1;
        bus.icache_req_raddr = 32'h7000;
        nx();
        nx();
        nx();
        lat_fixed = 2;
        chk("t4_ovf_before", 128'(bus.overflow), '0);
        for (int k = 0; k < 5; k++) begin
            bus.dcache_req_ren   = 1'b1;
            bus.dcache_req_raddr = 32'h3000 + 32'(k * 64);
            nx();
        end
        chk("t4_ovf_set", 128'(bus.overflow), 128'(1));
        wait_idle(200);
        chk("t4_ovf_sticky", 128'(bus.overflow), 128'(1));
        chk("t4_irec_n", 128'(irec_a.size() - bi), 128'(1));
        chk("t4_drec_n", 128'(drec_a.size() - bd), 128'(4));
        if (drec_a.size() >= bd + 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("t4_drec%0d", k), 128'(drec_a[bd+k]),
                    128'(32'h3000 + 32'(k * 64)));
        end

        // writeback then refill of the same line
        do_reset();
        lat_fixed = 0;
        bd = drec_a.size();
        bus.dcache_req_wen        = 1'b1;
        bus.dcache_req_waddr      = 32'h400;
        bus.dcache_req_wcacheline = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        nx();
        bus.dcache_req_ren   = 1'b1;
        bus.dcache_req_raddr = 32'h400;
        wait_idle(100);
        chk("t5_drec_n", 128'(drec_a.size() - bd), 128'(1));
        if (drec_a.size() > bd)
            chk("t5_drec_data", drec_d[bd], 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

        // reset in WAIT with two requests queued, then a stray response
        do_reset();
        lat_fixed = 10;
        bus.icache_req_ren   = 1'b1;
        bus.icache_req_raddr = 32'h500;
        nx();
        nx();
        nx();
        bus.dcache_req_ren   = 1'b1;
        bus.dcache_req_raddr = 32'h600;
        nx();
        bus.dcache_req_ren   = 1'b1;
        bus.dcache_req_raddr = 32'h640;
        nx();
        nx();
        rst = 1'b1;
        nx();
        nx();
        rst = 1'b0;
        late_cnt++;
        for (int k = 0; k < 6; k++) begin
            nx();
            chk($sformatf("t6_irec%0d", k), 128'(bus.icache_rec_en), '0);
            chk($sformatf("t6_drec%0d", k), 128'(bus.dcache_rec_en), '0);
            chk($sformatf("t6_mreq%0d", k), 128'(bus.mem_req_valid), '0);
            chk($sformatf("t6_busy%0d", k), 128'(bus.busy), '0);
        end
        lat_fixed = 0;

        // random traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.icache_req_ren        = ($urandom_range(0, 3) == 0);
            bus.icache_req_raddr      = {22'h0, 4'($urandom_range(0, 15)), 6'h0};
            bus.dcache_req_ren        = ($urandom_range(0, 3) == 0);
            bus.dcache_req_raddr      = {22'h0, 4'($urandom_range(0, 15)), 6'h0};
            bus.dcache_req_wen        = ($urandom_range(0, 5) == 0);
            bus.dcache_req_waddr      = {22'h0, 4'($urandom_range(0, 15)), 6'h0};
            bus.dcache_req_wcacheline = {$urandom, $urandom, $urandom, $urandom};
            nx();
            if (k == 200) begin
                rst = 1'b1;
                nx();
                rst = 1'b0;
            end
        end
        wait_idle(400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_total);
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction cache (line fills) and the data cache (line fills and dirty-line writebacks). Both caches fire one-cycle request pulses with no backpressure, so the arbiter captures every pulse into a per-source FIFO. It serialises the queued requests onto memory one transaction at a time and routes each fill response back to the cache that asked for it. It sits between the MMU caches and the memory model.

## Interface

Parameters:
- QDEPTH, 4: entries per request FIFO (power of two, ≥2).

Ports. Widths are `pptr_t` = 32 bits and `cacheline_t` = 128 bits. Reset is synchronous and active-high.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- icache_req_ren  in  1  icache fill request pulse.
- icache_req_raddr  in  pptr_t  line-aligned fill address.
- icache_rec_en  out  1  fill response pulse to icache.
- icache_rec_addr  out  pptr_t  address of the returned line.
- icache_rec_cacheline  out  cacheline_t  returned line.
- dcache_req_ren  in  1  dcache fill request pulse.
- dcache_req_raddr  in  pptr_t  fill address.
- dcache_req_wen  in  1  dcache writeback pulse. It may coincide with dcache_req_ren.
- dcache_req_waddr  in  pptr_t  writeback address.
- dcache_req_wcacheline  in  cacheline_t  writeback data.
- dcache_rec_en, dcache_rec_addr, dcache_rec_cacheline  out  1/pptr_t/cacheline_t  fill response to dcache.
- mem_req_valid  out  1  one-cycle transaction start.
- mem_req_we  out  1  1 = write, 0 = read.
- mem_req_addr  out  pptr_t  transaction address.
- mem_req_wdata  out  cacheline_t  write data.
- mem_rsp_valid  in  1  completion pulse, for both reads and writes.
- mem_rsp_data  in  cacheline_t  read data, valid with mem_rsp_valid.
- busy  out  1  any FIFO non-empty or FSM not IDLE.
- overflow  out  1  sticky: a request was dropped because its FIFO was full.

## Operation

- There are three FIFOs, each QDEPTH deep:
  - IQ holds icache read addresses.
  - DQ holds dcache read addresses.
  - WQ holds writeback address plus line.
- A request pulse pushes into its FIFO at that clock edge.
- A push to a full FIFO is dropped and sets overflow, unless the same FIFO pops in the same cycle; in that case the push succeeds.
- The FSM has three states: IDLE, ISSUE, WAIT.
- IDLE: if any FIFO is non-empty, select and pop one request, latch it, and go to ISSUE. Otherwise stay in IDLE.
- Selection priority:
  - WQ non-empty always wins. This guarantees an evicted line reaches memory before any later re-fill of it.
  - Otherwise IQ and DQ alternate round-robin. A last_grant bit is updated only on read grants; its reset value is "dcache", so the icache wins the first tie.
- ISSUE: drive mem_req_valid=1 with we/addr/wdata from the latch for exactly one cycle, then go to WAIT.
- WAIT: hold until mem_rsp_valid, then return to IDLE.
  - For a read, the next cycle pulses the owning cache's rec_en for one cycle with the latched address and the registered mem_rsp_data.
  - A write produces no cache response.
- mem_rsp_valid is ignored outside WAIT.
- Exactly one memory transaction is outstanding at any time.
- The rec_addr/rec_cacheline outputs hold their last value when rec_en=0. rec_en never asserts for both caches in the same cycle.

## Timing

- Reset values: every output is 0; all FIFOs are empty; FSM is IDLE; last_grant = dcache; overflow = 0.
- Reset mid-transaction discards all queued and in-flight requests. A late mem_rsp_valid that arrives after reset is ignored because the FSM is in IDLE.
- Read latency with memory latency L (mem_rsp_valid L cycles after mem_req_valid) and an idle arbiter:
  - pulse in cycle 0;
  - pop in cycle 1;
  - mem_req_valid in cycle 2;
  - mem_rsp_valid in cycle 2+L;
  - rec_en in cycle 3+L.
- Back-to-back: the FSM is in IDLE in the cycle rec_en pulses and may pop the next request in that same cycle. Sustained throughput is therefore one transaction per L+2 cycles.
- A simultaneous dcache ren+wen pushes both DQ and WQ. The writeback is issued first.
- FIFO pointers are log2(QDEPTH) bits plus one wrap bit. Full means the indices are equal and the wrap bits differ.
- busy falls in the cycle after the last response pulse when all FIFOs are empty.

## Test plan

- Single icache read of 0x0000_1040, memory L=3 returning 0xA5A5…: icache_rec_en in cycle 6, addr 0x0000_1040, data matches; dcache_rec_en stays 0; busy deasserts in cycle 7.
- Same-cycle icache read 0x100, dcache read 0x200 and dcache write 0x300: mem_req order is write 0x300, then read 0x100 (icache first after reset), then read 0x200. Exactly two response pulses occur, each routed correctly.
- Continuous requests from both caches (3 each): grants alternate I, D, I, D, I, D; no rec_en overlap.
- Five dcache reads pulsed in consecutive cycles with QDEPTH=4 while memory is stalled: the fifth request is dropped and overflow=1, and overflow stays 1. Exactly four dcache responses arrive, in push order.
- Writeback 0x400 with data X, then dcache read 0x400 in the next cycle: the memory model returns X for the read, proving the write was ordered first.
- Assert rst in WAIT with 2 entries queued, and pulse mem_rsp_valid one cycle after reset releases: no rec_en pulse, no mem_req_valid, and busy=0.
